psum_acc: RTL

Read-modify-write accumulation controller sitting directly upstream of the psum memory. Takes partial sums from the PE array, reads the stored psum at the target address, adds with signed saturation and writes the result back through the memory's write port. Also runs a drain sequence that reads a contiguous psum range out of memory as a stream for the downstream output stage. Handles the memory's one-cycle read latency and the read-after-write hazard of its own pipeline by forwarding.

---
 rtl/psum_acc_if.sv | 34 +++
 rtl/psum_acc.sv | 74 +++++++
 2 files changed

// File: rtl/psum_acc_if.sv
// psum_acc_if: accumulate input, drain control, psum memory port and drain stream of psum_acc
interface psum_acc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  i_valid;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_first;
  logic                  o_in_ready;
  logic                  i_drain_start;
  logic [ADDR_WIDTH-1:0] i_drain_base;
  logic [ADDR_WIDTH-1:0] i_drain_len;
  logic                  o_busy;
  logic                  o_pm_rd_en;
  logic [ADDR_WIDTH-1:0] o_pm_rd_addr;
  logic [DATA_WIDTH-1:0] i_pm_rd_data;
  logic                  o_pm_wr_en;
  logic [ADDR_WIDTH-1:0] o_pm_wr_addr;
  logic [DATA_WIDTH-1:0] o_pm_wr_data;
  logic                  o_out_valid;
  logic [DATA_WIDTH-1:0] o_out_data;
  logic                  o_out_last;
  modport slave (
    input  i_valid, i_addr, i_data, i_first, i_drain_start, i_drain_base, i_drain_len, i_pm_rd_data,
    output o_in_ready, o_busy, o_pm_rd_en, o_pm_rd_addr, o_pm_wr_en, o_pm_wr_addr, o_pm_wr_data,
           o_out_valid, o_out_data, o_out_last
  );
  modport master (
    output i_valid, i_addr, i_data, i_first, i_drain_start, i_drain_base, i_drain_len, i_pm_rd_data,
    input  o_in_ready, o_busy, o_pm_rd_en, o_pm_rd_addr, o_pm_wr_en, o_pm_wr_addr, o_pm_wr_data,
           o_out_valid, o_out_data, o_out_last
  );
endinterface

// File: rtl/psum_acc.sv
// psum_acc: saturating read-modify-write psum accumulator with forwarding and a streaming drain
module psum_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic       i_clk,
  input logic       i_rst,
  psum_acc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;
  localparam logic [DATA_WIDTH-1:0] MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  state_t                state, state_nx;
  logic                  accept, drain_rd, drain_end;
  logic                  s1_v, s1_first, s2_v, out_v, out_l;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr, d_addr, d_rem;
  logic [DATA_WIDTH-1:0] s1_data, s2_sum, operand, sum;
  logic [DATA_WIDTH:0]   full;
  always_comb begin
    accept    = bus.i_valid & (state == IDLE) & ~i_rst;
    drain_rd  = (state == DRAIN) & ~i_rst;
    drain_end = drain_rd & (d_rem == '0);
    // leave IDLE straight for DRAIN when the pipeline is already empty next cycle
    state_nx  = state == IDLE  ? (bus.i_drain_start ? ((accept | s1_v) ? FLUSH : DRAIN) : IDLE) :
                state == FLUSH ? (s1_v ? FLUSH : DRAIN) :
                state == DRAIN ? (d_rem == '0 ? IDLE : DRAIN) : IDLE;
    // S2 holds the write not yet visible in the read data S1 is consuming
    operand   = s1_first ? '0 : ((s2_v && s2_addr == s1_addr) ? s2_sum : bus.i_pm_rd_data);
    full      = {operand[DATA_WIDTH-1], operand} + {s1_data[DATA_WIDTH-1], s1_data};
    sum       = (full[DATA_WIDTH] != full[DATA_WIDTH-1]) ? (full[DATA_WIDTH] ? MIN : MAX)
                                                         : full[DATA_WIDTH-1:0];
  end
  assign bus.o_in_ready   = state == IDLE;
  assign bus.o_busy       = (state != IDLE) | out_l;
  assign bus.o_pm_rd_en   = drain_rd | (accept & ~bus.i_first);
  assign bus.o_pm_rd_addr = drain_rd ? d_addr : bus.i_addr;
  assign bus.o_pm_wr_en   = s2_v;
  assign bus.o_pm_wr_addr = s2_addr;
  assign bus.o_pm_wr_data = s2_sum;
  assign bus.o_out_valid  = out_v;
  assign bus.o_out_data   = bus.i_pm_rd_data;
  assign bus.o_out_last   = out_l;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      out_v <= 1'b0;
      out_l <= 1'b0;
    end else begin
      state <= state_nx;
      s1_v  <= accept;
      s2_v  <= s1_v;
      out_v <= drain_rd;
      out_l <= drain_end;
    end
  end
  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_addr  <= bus.i_addr;
      s1_data  <= bus.i_data;
      s1_first <= bus.i_first;
    end
    s2_addr <= s1_addr;
    s2_sum  <= sum;
    if (state == IDLE && bus.i_drain_start) begin
      d_addr <= bus.i_drain_base;
      d_rem  <= bus.i_drain_len;
    end else if (drain_rd) begin
      d_addr <= d_addr + 1'b1;
      d_rem  <= d_rem - 1'b1;
    end
  end
endmodule
